// File: rtl/aes_rom_pkg.sv
// Shared definitions for the AES S-box ROM arbiter slice: FSM encoding,
// table-select values for address bit 8, and default ROM wait timing.
// Pure declarations; no latency or backpressure of its own.
package aes_rom_pkg;

    // Arbiter FSM state encoding
    typedef enum logic [1:0] {
        ST_IDLE   = 2'h0,
        ST_SETUP  = 2'h1,
        ST_ACCESS = 2'h2,
        ST_DONE   = 2'h3
    } arb_state_e;

    // Value of rom address bit 8 selecting each table
    localparam logic SBOX_TABLE     = 1'b0;
    localparam logic INV_SBOX_TABLE = 1'b1;

    // Cycles rom_oe_n is held low before rom_data is sampled
    localparam int DEF_WAIT_CYCLES = 2;

    // Wait counter width, wide enough for WAIT_CYCLES up to 15
    localparam int WAIT_CNT_W = 4;

endpackage

// File: rtl/aes_rr_pick.sv
// Combinational round-robin picker: first set request at or above ptr, wrapping.
// Latency: zero cycles (pure combinational).
// Backpressure: none; grant is all-zero when no request is set.
module aes_rr_pick
    import aes_rom_pkg::*;
#(
    parameter int NUM_REQ = 3,
    parameter int IDX_W   = 2
) (
    input  logic [NUM_REQ-1:0] req,
    input  logic [IDX_W-1:0]   ptr,
    output logic [NUM_REQ-1:0] grant,
    output logic [IDX_W-1:0]   grant_idx
);

    logic found;
    int   idx;

    // Scan requesters starting at ptr and wrapping; first hit wins
    always_comb begin
        grant     = '0;
        grant_idx = '0;
        found     = 1'b0;
        idx       = 0;
        for (int k = 0; k < NUM_REQ; k++) begin
            idx = int'(ptr) + k;
            if (idx >= NUM_REQ) begin
                idx = idx - NUM_REQ;
            end
            if (!found && (idx < NUM_REQ) && req[IDX_W'(idx)]) begin
                found                = 1'b1;
                grant[IDX_W'(idx)]   = 1'b1;
                grant_idx            = IDX_W'(idx);
            end
        end
    end

endmodule

// File: rtl/aes_rom_arbiter.sv
// Arbitrates one shared 8-bit S-box ROM between AES requesters; AES_ROM_ARB_FIXED_PRIO_EN selects fixed priority.
// Latency: req seen in IDLE at cycle 0 -> ack at cycle 2+WAIT_CYCLES; one lookup per 3+WAIT_CYCLES cycles.
// Backpressure: losers hold req until their ack; a started access always completes (no abort).
module aes_rom_arbiter
    import aes_rom_pkg::*;
#(
    parameter int NUM_REQ     = 3,
    parameter int ROM_ADDR_W  = 9,
    parameter int WAIT_CYCLES = DEF_WAIT_CYCLES
) (
    input  logic                          clk,
    input  logic                          reset_n,
    input  logic [NUM_REQ-1:0]            req,
    input  logic [NUM_REQ*ROM_ADDR_W-1:0] req_addr,
    output logic [NUM_REQ-1:0]            ack,
    output logic [7:0]                    rsp_data,
    output logic                          busy,
    output logic [ROM_ADDR_W-1:0]         rom_addr,
    input  logic [7:0]                    rom_data,
    output logic                          rom_ce_n,
    output logic                          rom_oe_n
);

    localparam int IDX_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

    // Reject illegal configurations at elaboration
    if (NUM_REQ < 2 || NUM_REQ > 8) begin : g_bad_num_req
        $error("aes_rom_arbiter: NUM_REQ must be in 2..8");
    end
    if (WAIT_CYCLES < 1 || WAIT_CYCLES > 15) begin : g_bad_wait
        $error("aes_rom_arbiter: WAIT_CYCLES must be in 1..15");
    end

    arb_state_e              state;
    logic [IDX_W-1:0]        ptr;
    logic [IDX_W-1:0]        gnt_idx;
    logic [NUM_REQ-1:0]      gnt_oh;
    logic [WAIT_CNT_W-1:0]   wait_cnt;

    logic [IDX_W-1:0]        pick_ptr;
    logic [NUM_REQ-1:0]      pick_oh;
    logic [IDX_W-1:0]        pick_idx;
    logic [ROM_ADDR_W-1:0]   pick_addr;

`ifdef AES_ROM_ARB_FIXED_PRIO_EN
    // Fixed priority: always scan from requester 0 so the lowest index wins
    assign pick_ptr = '0;
`else
    assign pick_ptr = ptr;
`endif

    aes_rr_pick #(
        .NUM_REQ (NUM_REQ),
        .IDX_W   (IDX_W)
    ) u_pick (
        .req       (req),
        .ptr       (pick_ptr),
        .grant     (pick_oh),
        .grant_idx (pick_idx)
    );

    // Select the winning requester's address from the packed address bus
    always_comb begin
        pick_addr = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (pick_oh[i]) begin
                pick_addr = req_addr[i*ROM_ADDR_W +: ROM_ADDR_W];
            end
        end
    end

    // Arbiter FSM: grant in IDLE, sequence CE/OE timing, return byte with one-cycle ack
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state    <= ST_IDLE;
            ptr      <= '0;
            gnt_idx  <= '0;
            gnt_oh   <= '0;
            wait_cnt <= '0;
            ack      <= '0;
            rsp_data <= '0;
            busy     <= 1'b0;
            rom_addr <= '0;
            rom_ce_n <= 1'b1;
            rom_oe_n <= 1'b1;
        end else begin
            case (state)
                ST_IDLE: begin
                    // rom_addr only moves here, while the ROM is deselected
                    if (|req) begin
                        rom_addr <= pick_addr;
                        gnt_idx  <= pick_idx;
                        gnt_oh   <= pick_oh;
                        rom_ce_n <= 1'b0;
                        busy     <= 1'b1;
                        state    <= ST_SETUP;
                    end
                end
                ST_SETUP: begin
                    rom_oe_n <= 1'b0;
                    wait_cnt <= WAIT_CNT_W'(WAIT_CYCLES - 1);
                    state    <= ST_ACCESS;
                end
                ST_ACCESS: begin
                    if (wait_cnt != '0) begin
                        wait_cnt <= wait_cnt - 1'b1;
                    end else begin
                        rsp_data <= rom_data;
                        rom_ce_n <= 1'b1;
                        rom_oe_n <= 1'b1;
                        ack      <= gnt_oh;
                        state    <= ST_DONE;
                    end
                end
                ST_DONE: begin
                    ack   <= '0;
                    busy  <= 1'b0;
                    state <= ST_IDLE;
`ifndef AES_ROM_ARB_FIXED_PRIO_EN
                    // Next scan starts just past the requester served now
                    if (gnt_idx == IDX_W'(NUM_REQ - 1)) begin
                        ptr <= '0;
                    end else begin
                        ptr <= gnt_idx + 1'b1;
                    end
`endif
                end
                default: begin
                    ack      <= '0;
                    busy     <= 1'b0;
                    rom_ce_n <= 1'b1;
                    rom_oe_n <= 1'b1;
                    state    <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_aes_rom_arbiter.sv
// Directed self-checking bench for aes_rom_arbiter (default and WAIT_CYCLES=4 instances).
// Latency expectations: ack at cycle 2+WAIT_CYCLES after the req is seen in IDLE.
// Backpressure: requesters hold req until ack and drop it during the ack cycle.
module tb_aes_rom_arbiter;

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;

    // Default-parameter instance
    logic [2:0]  req = '0;
    logic [26:0] req_addr = '0;
    logic [2:0]  ack;
    logic [7:0]  rsp_data;
    logic        busy;
    logic [8:0]  rom_addr;
    logic [7:0]  rom_data;
    logic        rom_ce_n;
    logic        rom_oe_n;

    // WAIT_CYCLES=4 instance
    logic [2:0]  req_w4 = '0;
    logic [26:0] req_addr_w4 = '0;
    logic [2:0]  ack_w4;
    logic [7:0]  rsp_data_w4;
    logic        busy_w4;
    logic [8:0]  rom_addr_w4;
    logic [7:0]  rom_data_w4;
    logic        rom_ce_n_w4;
    logic        rom_oe_n_w4;

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk = ~clk;

    // ROM contents: two real table entries plus a simple scramble elsewhere
    function automatic logic [7:0] rom_fn(input logic [8:0] a);
        case (a)
            9'h100:  return 8'h52;
            9'h0A3:  return 8'h0A;
            default: return a[7:0] ^ {a[8], 7'h2B};
        endcase
    endfunction

    assign rom_data    = (!rom_ce_n && !rom_oe_n) ? rom_fn(rom_addr) : 8'hFF;
    assign rom_data_w4 = (!rom_ce_n_w4 && !rom_oe_n_w4) ? rom_fn(rom_addr_w4) : 8'hFF;

    aes_rom_arbiter dut (
        .clk      (clk),
        .reset_n  (reset_n),
        .req      (req),
        .req_addr (req_addr),
        .ack      (ack),
        .rsp_data (rsp_data),
        .busy     (busy),
        .rom_addr (rom_addr),
        .rom_data (rom_data),
        .rom_ce_n (rom_ce_n),
        .rom_oe_n (rom_oe_n)
    );

    aes_rom_arbiter #(.WAIT_CYCLES(4)) dut_w4 (
        .clk      (clk),
        .reset_n  (reset_n),
        .req      (req_w4),
        .req_addr (req_addr_w4),
        .ack      (ack_w4),
        .rsp_data (rsp_data_w4),
        .busy     (busy_w4),
        .rom_addr (rom_addr_w4),
        .rom_data (rom_data_w4),
        .rom_ce_n (rom_ce_n_w4),
        .rom_oe_n (rom_oe_n_w4)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Advance one clock and land 1 time unit after the rising edge
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    logic [8:0] t2_addr [3];
    int         exp_g;
    int         oe_low;

    initial begin
        // ---------------- reset values ----------------
        tick();
        tick();
        check("rst_ack",      32'(ack),      32'h0);
        check("rst_rsp",      32'(rsp_data), 32'h0);
        check("rst_rom_addr", 32'(rom_addr), 32'h0);
        check("rst_ce_n",     32'(rom_ce_n), 32'h1);
        check("rst_oe_n",     32'(rom_oe_n), 32'h1);
        check("rst_busy",     32'(busy),     32'h0);
        reset_n = 1'b1;
        tick();
        check("idle_ce_n", 32'(rom_ce_n), 32'h1);

        // ---------------- single request, requester 1 ----------------
        req = 3'b010;
        req_addr[9 +: 9] = 9'h100;
        for (int n = 1; n <= 5; n++) begin
            tick();
            check($sformatf("t1_ce_n_c%0d", n), 32'(rom_ce_n), (n >= 1 && n <= 3) ? 32'h0 : 32'h1);
            check($sformatf("t1_oe_n_c%0d", n), 32'(rom_oe_n), (n >= 2 && n <= 3) ? 32'h0 : 32'h1);
            check($sformatf("t1_ack_c%0d", n),  32'(ack),      (n == 4) ? 32'h2 : 32'h0);
            if (n <= 4) check($sformatf("t1_addr_c%0d", n), 32'(rom_addr), 32'h100);
            if (n == 4) begin
                check("t1_rsp", 32'(rsp_data), 32'h52);
                req = 3'b000;
            end
        end

        // ---------------- contention, fresh pointer ----------------
        reset_n = 1'b0;
        tick();
        reset_n = 1'b1;
        t2_addr[0] = 9'h011;
        t2_addr[1] = 9'h122;
        t2_addr[2] = 9'h033;
        for (int i = 0; i < 3; i++) req_addr[i*9 +: 9] = t2_addr[i];
        req = 3'b111;
        for (int n = 1; n <= 30; n++) begin
            tick();
`ifdef AES_ROM_ARB_FIXED_PRIO_EN
            exp_g = 0;
`else
            exp_g = ((n - 4) / 5) % 3;
`endif
            check($sformatf("t2_busy_c%0d", n), 32'(busy), (n % 5 != 0) ? 32'h1 : 32'h0);
            if (n % 5 == 4) begin
                check($sformatf("t2_ack_c%0d", n), 32'(ack), 32'(3'b001 << exp_g));
                check($sformatf("t2_rsp_c%0d", n), 32'(rsp_data), 32'(rom_fn(t2_addr[exp_g])));
            end else begin
                check($sformatf("t2_ack_c%0d", n), 32'(ack), 32'h0);
            end
            if (n == 29) req = 3'b000;
        end

        // ---------------- WAIT_CYCLES=4 instance ----------------
        req_w4 = 3'b001;
        req_addr_w4[0 +: 9] = 9'h0A3;
        oe_low = 0;
        for (int n = 1; n <= 8; n++) begin
            tick();
            if (!rom_oe_n_w4) oe_low++;
            check($sformatf("t3_ack_c%0d", n), 32'(ack_w4), (n == 6) ? 32'h1 : 32'h0);
            if (n == 6) begin
                check("t3_rsp", 32'(rsp_data_w4), 32'h0A);
                req_w4 = 3'b000;
            end
        end
        check("t3_oe_low_cycles", 32'(oe_low), 32'd4);

        // ---------------- reset during ACCESS ----------------
        req = 3'b001;
        req_addr[0 +: 9] = 9'h055;
        tick();
        tick();
        check("t4_in_access_oe_n", 32'(rom_oe_n), 32'h0);
        reset_n = 1'b0;
        req = 3'b000;
        #1;
        check("t4_async_ce_n", 32'(rom_ce_n), 32'h1);
        check("t4_async_oe_n", 32'(rom_oe_n), 32'h1);
        tick();
        check("t4_no_ack", 32'(ack), 32'h0);
        reset_n = 1'b1;
        req = 3'b100;
        req_addr[18 +: 9] = 9'h1C4;
        for (int n = 1; n <= 4; n++) begin
            tick();
            if (n == 1) check("t4_addr", 32'(rom_addr), 32'h1C4);
            if (n < 4)  check($sformatf("t4_ack_c%0d", n), 32'(ack), 32'h0);
        end
        check("t4_ack", 32'(ack), 32'h4);
        check("t4_rsp", 32'(rsp_data), 32'(rom_fn(9'h1C4)));
        req = 3'b000;

        // ---------------- req[0] dropped during SETUP ----------------
        tick();
        req = 3'b001;
        req_addr[0 +: 9] = 9'h0F0;
        for (int n = 1; n <= 9; n++) begin
            tick();
            if (n == 1) begin
                check("t5_setup_ce_n", 32'(rom_ce_n), 32'h0);
                check("t5_setup_oe_n", 32'(rom_oe_n), 32'h1);
                req = 3'b000;
            end
            if (n == 4) begin
                check("t5_ack0", 32'(ack), 32'h1);
                check("t5_rsp0", 32'(rsp_data), 32'(rom_fn(9'h0F0)));
                req = 3'b010;
                req_addr[9 +: 9] = 9'h1F1;
            end
            if (n == 5) check("t5_idle_busy", 32'(busy), 32'h0);
            if (n == 6) check("t5_addr1", 32'(rom_addr), 32'h1F1);
            if (n == 9) begin
                check("t5_ack1", 32'(ack), 32'h2);
                check("t5_rsp1", 32'(rsp_data), 32'(rom_fn(9'h1F1)));
                req = 3'b000;
            end
        end
        tick();
        check("t5_final_ack", 32'(ack), 32'h0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/aes_rom_arbiter.md
Name: aes_rom_arbiter

Overview:
- Arbitrates one shared external 8-bit parallel S-box ROM between several AES requesters: the encipher S-box, the decipher inverse S-box and the key-expansion S-box.
- Each requester issues a byte-lookup request; the arbiter sequences ROM chip-enable/output-enable timing and returns the byte with a one-cycle ack.
- Sits between the cipher/key blocks and the ROM pins at top level.

Parameters:
- NUM_REQ, 3, number of requesters (2..8).
- ROM_ADDR_W, 9, ROM address width; bit 8 selects the table (0 = S-box, 1 = inverse S-box).
- WAIT_CYCLES, 2, cycles rom_oe_n is held low before rom_data is sampled (1..15).

Ports:
- clk  in  1  system clock
- reset_n  in  1  asynchronous active-low reset
- req  in  NUM_REQ  per-requester request level
- req_addr  in  NUM_REQ*ROM_ADDR_W  packed addresses; requester i at [i*ROM_ADDR_W +: ROM_ADDR_W]
- ack  out  NUM_REQ  one-cycle pulse; rsp_data is valid for the requester whose bit is set
- rsp_data  out  8  registered ROM byte
- busy  out  1  high in any state other than IDLE
- rom_addr  out  ROM_ADDR_W  registered ROM address
- rom_data  in  8  ROM data bus
- rom_ce_n  out  1  ROM chip enable, active low
- rom_oe_n  out  1  ROM output enable, active low

Behaviour:
- Clock and reset: one clock, clk; reset_n is asynchronous and active-low.
- Reset values: state IDLE, ack=0, rsp_data=0, rom_addr=0, rom_ce_n=1, rom_oe_n=1, busy=0, rr pointer=0, wait counter=0.
- All outputs are registered.
- FSM states: IDLE, SETUP, ACCESS, DONE.
- IDLE, no req bit set: stay in IDLE.
- IDLE, any req bit set:
  - Choose the winner g round-robin: the first set bit at or above the pointer, wrapping.
  - Latch rom_addr from req_addr[g] and latch g.
  - Drive rom_ce_n=0, go to SETUP.
- SETUP (1 cycle): rom_ce_n=0, rom_oe_n=1. Set rom_oe_n=0, load counter=WAIT_CYCLES-1, go to ACCESS.
- ACCESS:
  - rom_ce_n=0, rom_oe_n=0.
  - Counter != 0: decrement, stay.
  - Counter == 0: capture rom_data into rsp_data, set rom_ce_n=rom_oe_n=1, set ack[g]=1, go to DONE.
- DONE (1 cycle): ack[g] high; pointer <= (g+1) mod NUM_REQ; next cycle ack=0 and state IDLE.
- Latency: req seen in IDLE at cycle 0 -> ack at cycle 2+WAIT_CYCLES (cycle 4 at default).
- Throughput: one lookup per 3+WAIT_CYCLES cycles.
- Requester rules:
  - Hold req and req_addr stable until its ack.
  - Deassert req in the cycle after ack unless a new lookup is wanted; req still high in the next IDLE cycle counts as a new request.
- req withdrawn mid-transaction: the access completes, ack still pulses, pointer still advances. No abort.
- Simultaneous requests: exactly one winner; the others wait. Under continuous contention each requester is served within NUM_REQ transactions.
- rom_addr changes only in IDLE, never while rom_ce_n=0.
- Pointer wraps from NUM_REQ-1 to 0.
- Reset asserted mid-access: immediately rom_ce_n=rom_oe_n=1, no ack. Requesters must reissue.
- Out-of-range parameters (WAIT_CYCLES=0, NUM_REQ<2) are illegal; an elaboration-time check stops with $error.

Optional Feature:
- AES_ROM_ARB_FIXED_PRIO_EN defined: fixed priority, lowest set index wins; the pointer is neither used nor updated and stays 0.
- Undefined: round-robin as described above.

Decomposition:
- Shared package aes_rom_pkg holds:
  - FSM state encoding (IDLE=2'h0, SETUP=2'h1, ACCESS=2'h2, DONE=2'h3)
  - SBOX_TABLE=1'b0, INV_SBOX_TABLE=1'b1
  - default WAIT_CYCLES
- One sub-module, aes_rr_pick: combinational round-robin picker. Inputs are req and pointer; outputs are a one-hot grant and a binary index.

Test Plan:
- Single request: req[1]=1, req_addr1=0x100, ROM model returns 0x52 -> ack[1] at cycle 4, rsp_data=0x52; rom_ce_n low cycles 1-3, rom_oe_n low cycles 2-3.
- All three req high continuously, distinct addresses -> acks in order 0,1,2,0,1,2, each 5 cycles apart; each rsp_data matches its address.
- WAIT_CYCLES=4 build, req[0] addr 0x0A3 -> ack at cycle 6, rsp_data=S-box(0xA3)=0x0A; rom_oe_n low for exactly 4 cycles.
- reset_n pulsed low during ACCESS -> rom_ce_n/rom_oe_n go to 1 asynchronously, no ack; after release with req[2]=1, grant goes to 2 and the transaction completes normally.
- req[0] dropped during SETUP -> ack[0] still pulses at cycle 4; the next IDLE with req[1]=1 grants 1.
- AES_ROM_ARB_FIXED_PRIO_EN build, req[0] and req[2] held high -> requester 0 served every transaction; req[2] is never acked while req[0] stays high.
